// File: rtl/bcount_pkg.sv
// bcount_pkg: shared types, constants and successor rule for the mod-9 counter link
package bcount_pkg;
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  localparam logic [3:0] CNT_MAX = 4'd8;
  localparam logic [3:0] CNT_RST = 4'hF;
  function automatic logic [31:0] succ(input logic [31:0] v, input logic [31:0] max_v,
                                       input logic [31:0] rst_v);
    return (v == max_v || v == rst_v) ? 32'd0 : v + 32'd1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit incrementer with enable that holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (en && count_q != '1) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk) count_q <= !rst ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/bcount_checker.sv
// bcount_checker: locks onto the mod-9 count stream, flags and counts out-of-sequence samples
module bcount_checker
  import bcount_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 8,
  parameter int RST_VAL  = 15,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic             restart_pulse,
  output logic [WIDTH-1:0] expected
);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  state_t           state_q, state_d;
  logic             seeded_q, seeded_d;
  logic [2:0]       streak_q, streak_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             from_max_q, from_max_d;
  logic             err_q, err_d, wrap_q, wrap_d, restart_q, restart_d;
  logic             legal, hit;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    legal      = cnt_in <= MAX_W || cnt_in == RST_W;
    hit        = cnt_in == exp_q;
    nxt        = WIDTH'(succ(32'(cnt_in), 32'(MAX_VAL), 32'(RST_VAL)));
    state_d    = state_q;
    seeded_d   = seeded_q;
    streak_d   = streak_q;
    exp_d      = exp_q;
    from_max_d = from_max_q;
    err_d      = 1'b0;
    wrap_d     = 1'b0;
    restart_d  = 1'b0;
    if (cnt_valid) begin
      if (state_q == LOCKED) begin
        if (hit) begin
          wrap_d     = cnt_in == '0 && from_max_q;
          exp_d      = nxt;
          from_max_d = cnt_in == MAX_W;
        end else if (cnt_in == RST_W) begin
          restart_d  = 1'b1;
          exp_d      = '0;
          from_max_d = 1'b0;
        end else begin
          err_d      = 1'b1;
          state_d    = UNLOCKED;
          seeded_d   = legal;
          streak_d   = '0;
          exp_d      = legal ? nxt : exp_q;
          from_max_d = cnt_in == MAX_W;
        end
      end else if (!legal) begin
        seeded_d = 1'b0;
        streak_d = '0;
      end else begin
        // a match only counts toward lock once a seed exists
        exp_d      = nxt;
        from_max_d = cnt_in == MAX_W;
        seeded_d   = 1'b1;
        streak_d   = (seeded_q && hit) ? streak_q + 3'd1 : 3'd0;
        if (seeded_q && hit && streak_q + 3'd1 == 3'(LOCK_CNT)) begin
          state_d  = LOCKED;
          streak_d = '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= UNLOCKED;
      seeded_q   <= 1'b0;
      streak_q   <= '0;
      exp_q      <= RST_W;
      from_max_q <= 1'b0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seeded_q   <= seeded_d;
      streak_q   <= streak_d;
      exp_q      <= exp_d;
      from_max_q <= from_max_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      restart_q  <= restart_d;
    end
  end
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (err_d),
    .count(err_count)
  );
  assign locked        = state_q == LOCKED;
  assign err_pulse     = err_q;
  assign wrap_pulse    = wrap_q;
  assign restart_pulse = restart_q;
  assign expected      = exp_q;
endmodule

// File: tb/tb_bcount_checker.sv
// tb_bcount_checker: directed vector table plus randomized stream against a behavioural model
module tb_bcount_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cnt_valid = 1'b0;
  logic [3:0] cnt_in = '0;
  logic       locked, err_pulse, wrap_pulse, restart_pulse;
  logic [7:0] err_count;
  logic [3:0] expected;
  logic       s_locked, s_err, s_wrap, s_restart;
  logic [1:0] s_err_count;
  logic [3:0] s_expected;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  bcount_checker dut (
    .clk(clk), .rst(rst), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .wrap_pulse(wrap_pulse),
    .restart_pulse(restart_pulse), .expected(expected)
  );
  bcount_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .locked(s_locked),
    .err_pulse(s_err), .err_count(s_err_count), .wrap_pulse(s_wrap),
    .restart_pulse(s_restart), .expected(s_expected)
  );
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
  endtask
  // reference model: spec rules over plain integers; src is the sample that produced m_exp
  int  m_exp, m_err, m_streak, m_src;
  bit  m_lock, m_seeded, p_err, p_wrap, p_rst;
  task automatic model(input bit r, input bit vld, input int v);
    bit legal;
    int nx;
    p_err = 0; p_wrap = 0; p_rst = 0;
    legal = (v <= 8) || (v == 15);
    nx = (v == 8 || v == 15) ? 0 : v + 1;
    if (!r) begin
      m_lock = 0; m_seeded = 0; m_streak = 0; m_exp = 15; m_err = 0; m_src = -1;
    end else if (vld) begin
      if (m_lock) begin
        if (v == m_exp) begin
          p_wrap = (v == 0 && m_src == 8); m_exp = nx; m_src = v;
        end else if (v == 15) begin
          p_rst = 1; m_exp = 0; m_src = -1;
        end else begin
          p_err = 1; m_err++; m_lock = 0; m_streak = 0; m_seeded = legal;
          if (legal) begin m_exp = nx; m_src = v; end
        end
      end else if (!legal) begin
        m_seeded = 0; m_streak = 0;
      end else if (m_seeded && v == m_exp) begin
        m_streak++; m_exp = nx; m_src = v;
        if (m_streak == 2) begin m_lock = 1; m_streak = 0; end
      end else begin
        m_seeded = 1; m_exp = nx; m_streak = 0; m_src = v;
      end
    end
  endtask
  task automatic step(input bit r, input bit vld, input logic [3:0] v);
    rst = r; cnt_valid = vld; cnt_in = v;
    @(posedge clk);
    #1;
    model(r, vld, int'(v));
  endtask
  typedef struct {
    bit r; bit vld; logic [3:0] v;
    bit lk; bit er; bit wr; bit rs; int ec; logic [3:0] ex;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input bit r, input bit vld, input logic [3:0] v, input bit lk,
                     input bit er, input bit wr, input bit rs, input int ec, input logic [3:0] ex);
    vec_t t;
    t.r = r; t.vld = vld; t.v = v; t.lk = lk; t.er = er; t.wr = wr; t.rs = rs; t.ec = ec; t.ex = ex;
    tbl.push_back(t);
  endtask
  initial begin
    //   r vld v     lk er wr rs ec ex
    add(0, 0, 4'h0, 0, 0, 0, 0, 0, 4'hF);
    add(1, 1, 4'hF, 0, 0, 0, 0, 0, 4'h0);
    add(1, 1, 4'h0, 0, 0, 0, 0, 0, 4'h1);
    add(1, 1, 4'h1, 1, 0, 0, 0, 0, 4'h2);
    for (int i = 2; i <= 7; i++) add(1, 1, 4'(i), 1, 0, 0, 0, 0, 4'(i + 1));
    add(1, 1, 4'h8, 1, 0, 0, 0, 0, 4'h0);
    add(1, 1, 4'h0, 1, 0, 1, 0, 0, 4'h1);
    add(1, 0, 4'h0, 1, 0, 0, 0, 0, 4'h1);
    add(1, 1, 4'h1, 1, 0, 0, 0, 0, 4'h2);
    add(1, 1, 4'h2, 1, 0, 0, 0, 0, 4'h3);
    add(1, 1, 4'h5, 0, 1, 0, 0, 1, 4'h6);
    add(1, 1, 4'h6, 0, 0, 0, 0, 1, 4'h7);
    add(1, 1, 4'h7, 1, 0, 0, 0, 1, 4'h8);
    add(1, 1, 4'h8, 1, 0, 0, 0, 1, 4'h0);
    add(1, 1, 4'h0, 1, 0, 1, 0, 1, 4'h1);
    add(1, 1, 4'h1, 1, 0, 0, 0, 1, 4'h2);
    add(1, 1, 4'h2, 1, 0, 0, 0, 1, 4'h3);
    add(1, 1, 4'h3, 1, 0, 0, 0, 1, 4'h4);
    add(1, 1, 4'hF, 1, 0, 0, 1, 1, 4'h0);
    add(1, 1, 4'h0, 1, 0, 0, 0, 1, 4'h1);
    add(1, 1, 4'h5, 0, 1, 0, 0, 2, 4'h6);
    add(1, 1, 4'h3, 0, 0, 0, 0, 2, 4'h4);
    add(1, 1, 4'hA, 0, 0, 0, 0, 2, 4'h4);
    add(1, 1, 4'h4, 0, 0, 0, 0, 2, 4'h5);
    add(1, 1, 4'h5, 0, 0, 0, 0, 2, 4'h6);
    add(1, 1, 4'h6, 1, 0, 0, 0, 2, 4'h7);
    add(1, 1, 4'hB, 0, 1, 0, 0, 3, 4'h7);
    add(1, 1, 4'h7, 0, 0, 0, 0, 3, 4'h8);
    add(1, 1, 4'h8, 0, 0, 0, 0, 3, 4'h0);
    add(1, 1, 4'h0, 1, 0, 0, 0, 3, 4'h1);
    add(1, 1, 4'h2, 0, 1, 0, 0, 4, 4'h3);
    add(0, 1, 4'h3, 0, 0, 0, 0, 0, 4'hF);
    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].vld, tbl[k].v);
      chk($sformatf("vec%0d locked", k), locked, tbl[k].lk);
      chk($sformatf("vec%0d err_pulse", k), err_pulse, tbl[k].er);
      chk($sformatf("vec%0d wrap_pulse", k), wrap_pulse, tbl[k].wr);
      chk($sformatf("vec%0d restart_pulse", k), restart_pulse, tbl[k].rs);
      chk($sformatf("vec%0d err_count", k), err_count, tbl[k].ec);
      chk($sformatf("vec%0d expected", k), expected, tbl[k].ex);
      chk($sformatf("vec%0d sat err_count", k), s_err_count, tbl[k].ec > 3 ? 3 : tbl[k].ec);
    end
    step(0, 0, 4'h0);
    for (int n = 0; n < 600; n++) begin
      bit r, vld;
      logic [3:0] v;
      r = $urandom_range(99) >= 2;
      vld = $urandom_range(99) < 80;
      v = ($urandom_range(99) < 75) ? 4'(m_exp) : 4'($urandom_range(15));
      step(r, vld, v);
      chk("rnd locked", locked, m_lock);
      chk("rnd err_pulse", err_pulse, p_err);
      chk("rnd wrap_pulse", wrap_pulse, p_wrap);
      chk("rnd restart_pulse", restart_pulse, p_rst);
      chk("rnd expected", expected, m_exp);
      chk("rnd err_count", err_count, m_err > 255 ? 255 : m_err);
      chk("rnd sat err_count", s_err_count, m_err > 3 ? 3 : m_err);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcount_checker.md
Name: bcount_checker

Overview:
- Receive-side sequence checker for the 4-bit mod-9 binary counter stream. That stream resets to 4'hF, then runs 0,1,...,8,0,...
- Samples the count bus when valid, locks onto the sequence, flags every out-of-sequence value and counts errors.
- Sits at the consumer end of the counter link and feeds status and error telemetry to the system monitor.

Parameters:
WIDTH, 4, count bus width.
MAX_VAL, 8, terminal count; the successor of MAX_VAL is 0.
RST_VAL, 15, generator reset value; its successor is 0.
LOCK_CNT, 2, consecutive matching transitions required to lock (1..7).
ERR_W, 8, error counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
cnt_valid  input  1  cnt_in is sampled this cycle
cnt_in  input  WIDTH  observed count value
locked  output  1  checker is locked to the sequence
err_pulse  output  1  one-cycle pulse: mismatch detected while locked
err_count  output  ERR_W  total mismatches, saturating
wrap_pulse  output  1  one-cycle pulse: valid MAX_VAL to 0 transition while locked
restart_pulse  output  1  one-cycle pulse: RST_VAL sampled while locked
expected  output  WIDTH  next value predicted by the checker

Behaviour:
- All outputs are registered. A response appears 1 cycle after the sampling edge.
- Reset (rst=0 at a clk edge) drives the following state:
  - state=UNLOCKED, seeded=0, streak=0.
  - locked=0, err_pulse=0, wrap_pulse=0, restart_pulse=0.
  - err_count=0, expected=RST_VAL.
- Reset mid-stream discards all progress. Reset has priority over cnt_valid in the same cycle.
- Legal values are 0..MAX_VAL and RST_VAL. Other values are illegal (9..14 at default parameters).
- succ(v) is 0 when v==MAX_VAL or v==RST_VAL, else v+1. The +1 is computed WIDTH-bit with no carry out.
- cnt_valid=0: no state change, and all pulses deassert.
- UNLOCKED state:
  - Illegal sample: seeded=0, streak=0, no error.
  - Legal sample with seeded=0: seeded=1, expected=succ(sample), streak=0.
  - Legal sample with seeded=1 and sample==expected: streak+1, expected=succ(sample). When streak reaches LOCK_CNT, go to LOCKED, set locked=1 and clear streak.
  - Legal sample with seeded=1 and sample!=expected: re-seed (expected=succ(sample), streak=0). No error is reported while unlocked.
- LOCKED state:
  - sample==expected: expected=succ(sample). If the sample is 0 and the previous expected came from MAX_VAL, pulse wrap_pulse.
  - sample==RST_VAL when expected!=RST_VAL: the generator was reset. This is not an error. Pulse restart_pulse, set expected=0, stay LOCKED.
  - Any other sample: pulse err_pulse and increment err_count; it holds at all-ones once saturated. Go to UNLOCKED and set locked=0.
    - If the sample is legal, seed from it: seeded=1, expected=succ(sample), streak=0.
    - If the sample is illegal: seeded=0.
- Simultaneous events: err_pulse, wrap_pulse and restart_pulse are mutually exclusive by construction.
- err_count never wraps.

Decomposition:
- Shared package bcount_pkg holds:
  - state enum {UNLOCKED, LOCKED}.
  - constants CNT_MAX=8 and CNT_RST=4'hF, also used by the generator side.
  - function succ().
- Natural sub-module: sat_counter (ERR_W-bit saturating incrementer with enable) for err_count.

Test Plan:
- Reset then valid stream F,0,1 -> locked=1 one cycle after the 1 is sampled; expected=2; err_count=0.
- Locked stream 6,7,8,0 -> wrap_pulse high for exactly one cycle after the 0; expected=1; no err_pulse.
- Locked expecting 3, sample 5 -> err_pulse 1 cycle, err_count=1, locked=0, expected=6. Then 6,7 -> relock (locked=1).
- Locked expecting 4, sample F then 0 -> restart_pulse once, no error, locked stays 1, expected=1 after the 0.
- Unlocked, samples 3,A,4,5 -> A clears the seed. Lock needs a new seed plus LOCK_CNT matches (4 seeds, then 5 and 6); no err_count change.
- ERR_W=2: force 4 lock/mismatch cycles -> err_count stays 3. Drive rst=0 mid-stream with cnt_valid=1 -> all outputs return to reset values next cycle.
